// File: rtl/fetch_stage_if.sv
// fetch_stage_if: fetch-stage bus bundling the instruction-memory port, fetch control and the IF/ID register outputs
interface fetch_stage_if #(
  parameter int PC_WIDTH  = 5,
  parameter int CNT_WIDTH = 16
);
  logic [PC_WIDTH-1:0]  pc;
  logic                 imem_reset;
  logic [31:0]          instr;
  logic                 stall;
  logic                 branch_taken;
  logic [PC_WIDTH-1:0]  branch_target;
  logic [31:0]          if_id_instr;
  logic [PC_WIDTH-1:0]  if_id_pc;
  logic                 if_id_valid;
  logic                 halted;
  logic [CNT_WIDTH-1:0] fetch_count;
  modport master (
    output pc, imem_reset, if_id_instr, if_id_pc, if_id_valid, halted, fetch_count,
    input  instr, stall, branch_taken, branch_target
  );
  modport slave (
    input  pc, imem_reset, if_id_instr, if_id_pc, if_id_valid, halted, fetch_count,
    output instr, stall, branch_taken, branch_target
  );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: program counter, combinational imem fetch and IF/ID register with boot, stall, branch and halt
module fetch_stage #(
  parameter int                  PC_WIDTH   = 5,
  parameter logic [PC_WIDTH-1:0] RESET_PC   = '0,
  parameter logic [31:0]         NOP_INSTR  = 32'h0000_0000,
  parameter logic [31:0]         HALT_INSTR = 32'hFFFF_FFFF,
  parameter int                  CNT_WIDTH  = 16
) (
  input  logic          clk,
  input  logic          reset,
  fetch_stage_if.master f
);
  typedef enum logic [1:0] {BOOT, RUN, HALTED} state_t;
  state_t               state, state_n;
  logic [PC_WIDTH-1:0]  pc_q, pc_n, ipc_q, ipc_n;
  logic [31:0]          ins_q, ins_n;
  logic                 v_q, v_n;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_n;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= BOOT;
      pc_q  <= RESET_PC;
      ipc_q <= '0;
      ins_q <= NOP_INSTR;
      v_q   <= 1'b0;
      cnt_q <= '0;
    end else begin
      state <= state_n;
      pc_q  <= pc_n;
      ipc_q <= ipc_n;
      ins_q <= ins_n;
      v_q   <= v_n;
      cnt_q <= cnt_n;
    end
  end
  // branch beats stall in RUN; in HALTED only a branch restarts fetch
  always_comb begin
    state_n = state;
    pc_n    = pc_q;
    ipc_n   = ipc_q;
    ins_n   = ins_q;
    v_n     = v_q;
    cnt_n   = cnt_q;
    if (state == BOOT) begin
      state_n = RUN;
    end else if (state == RUN) begin
      if (f.branch_taken) begin
        pc_n  = f.branch_target;
        ins_n = NOP_INSTR;
        v_n   = 1'b0;
      end else if (!f.stall) begin
        ins_n   = f.instr;
        ipc_n   = pc_q;
        v_n     = 1'b1;
        cnt_n   = &cnt_q ? cnt_q : cnt_q + CNT_WIDTH'(1);
        state_n = (f.instr == HALT_INSTR) ? HALTED : RUN;
        pc_n    = (f.instr == HALT_INSTR) ? pc_q : pc_q + PC_WIDTH'(1);
      end
    end else begin
      ins_n   = NOP_INSTR;
      v_n     = 1'b0;
      pc_n    = f.branch_taken ? f.branch_target : pc_q;
      state_n = f.branch_taken ? RUN : HALTED;
    end
  end
  assign f.pc          = pc_q;
  assign f.imem_reset  = !reset || state == BOOT;
  assign f.if_id_instr = ins_q;
  assign f.if_id_pc    = ipc_q;
  assign f.if_id_valid = v_q;
  assign f.halted      = state == HALTED;
  assign f.fetch_count = cnt_q;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: table vectors, hand-written corner sequences and randomized run against a behavioural model
module tb_fetch_stage;
  localparam int PW = 5;
  localparam int CW = 16;
  localparam logic [31:0] HALT = 32'hFFFF_FFFF;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  fetch_stage_if #(.PC_WIDTH(PW), .CNT_WIDTH(CW)) f();
  fetch_stage #(.PC_WIDTH(PW), .CNT_WIDTH(CW)) dut (.clk(clk), .reset(reset), .f(f));
  logic [31:0] mem [32];
  assign f.instr = mem[f.pc];
  int vectors = 0;
  int miscompares = 0;
  int          m_st;
  logic [4:0]  m_pc, m_ipc;
  logic [31:0] m_ins;
  logic        m_v;
  int          m_cnt;
  typedef struct {
    logic s, b; logic [4:0] t;
    logic [4:0] ipc; logic [31:0] ins; logic v; logic [4:0] pc; int cnt;
  } vec_t;
  vec_t tbl [12];
  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got %h expected %h at %0t", n, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    m_st = 0; m_pc = 0; m_ipc = 0; m_ins = 0; m_v = 0; m_cnt = 0;
  endtask
  task automatic model_edge();
    if (m_st == 0) m_st = 1;
    else if (m_st == 1) begin
      if (f.branch_taken) begin
        m_pc = f.branch_target; m_ins = 0; m_v = 0;
      end else if (!f.stall) begin
        m_ins = mem[m_pc]; m_ipc = m_pc; m_v = 1;
        if (m_cnt < 65535) m_cnt++;
        if (m_ins == HALT) m_st = 2; else m_pc = m_pc + 5'd1;
      end
    end else begin
      m_ins = 0; m_v = 0;
      if (f.branch_taken) begin m_pc = f.branch_target; m_st = 1; end
    end
  endtask
  task automatic check_model();
    chk("pc", 32'(f.pc), 32'(m_pc));
    chk("if_id_instr", f.if_id_instr, m_ins);
    chk("if_id_pc", 32'(f.if_id_pc), 32'(m_ipc));
    chk("if_id_valid", 32'(f.if_id_valid), 32'(m_v));
    chk("halted", 32'(f.halted), 32'(m_st == 2));
    chk("imem_reset", 32'(f.imem_reset), 32'(m_st == 0));
    chk("fetch_count", 32'(f.fetch_count), 32'(m_cnt));
  endtask
  task automatic drive(input logic s, input logic b, input logic [4:0] t);
    f.stall = s; f.branch_taken = b; f.branch_target = t;
  endtask
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask
  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
  initial begin
    foreach (mem[i]) mem[i] = 32'h0;
    mem[0] = 32'h200; mem[1] = 32'h201; mem[2] = 32'h204; mem[3] = 32'h108;
    tbl[0]  = '{0, 0, 0,  0,  32'h200, 1, 1, 1};
    tbl[1]  = '{0, 0, 0,  1,  32'h201, 1, 2, 2};
    tbl[2]  = '{1, 0, 0,  1,  32'h201, 1, 2, 2};
    tbl[3]  = '{1, 0, 0,  1,  32'h201, 1, 2, 2};
    tbl[4]  = '{1, 0, 0,  1,  32'h201, 1, 2, 2};
    tbl[5]  = '{0, 0, 0,  2,  32'h204, 1, 3, 3};
    tbl[6]  = '{0, 0, 0,  3,  32'h108, 1, 4, 4};
    tbl[7]  = '{1, 1, 3,  3,  32'h0,   0, 3, 4};
    tbl[8]  = '{0, 0, 0,  3,  32'h108, 1, 4, 5};
    tbl[9]  = '{0, 1, 31, 3,  32'h0,   0, 31, 5};
    tbl[10] = '{0, 0, 0,  31, 32'h0,   1, 0, 6};
    tbl[11] = '{0, 0, 0,  0,  32'h200, 1, 1, 7};
    drive(0, 0, 0);
    model_reset();
    #12;
    chk("rst pc", 32'(f.pc), 0);
    chk("rst valid", 32'(f.if_id_valid), 0);
    chk("rst imem_reset", 32'(f.imem_reset), 1);
    chk("rst count", 32'(f.fetch_count), 0);
    chk("rst instr", f.if_id_instr, 0);
    reset = 1'b1;
    #1;
    chk("boot imem_reset", 32'(f.imem_reset), 1);
    step();
    chk("after boot imem_reset", 32'(f.imem_reset), 0);
    chk("after boot valid", 32'(f.if_id_valid), 0);
    chk("after boot pc", 32'(f.pc), 0);
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].s, tbl[i].b, tbl[i].t);
      step();
      chk($sformatf("tbl%0d ipc", i), 32'(f.if_id_pc), 32'(tbl[i].ipc));
      chk($sformatf("tbl%0d instr", i), f.if_id_instr, tbl[i].ins);
      chk($sformatf("tbl%0d valid", i), 32'(f.if_id_valid), 32'(tbl[i].v));
      chk($sformatf("tbl%0d pc", i), 32'(f.pc), 32'(tbl[i].pc));
      chk($sformatf("tbl%0d count", i), 32'(f.fetch_count), 32'(tbl[i].cnt));
      check_model();
    end
    mem[2] = HALT;
    drive(0, 1, 0); step();
    drive(0, 0, 0); step(); step(); step();
    chk("halt ipc", 32'(f.if_id_pc), 2);
    chk("halt instr", f.if_id_instr, HALT);
    chk("halt valid", 32'(f.if_id_valid), 1);
    chk("halt flag", 32'(f.halted), 1);
    chk("halt pc", 32'(f.pc), 2);
    drive(1, 0, 0); step();
    chk("halted valid", 32'(f.if_id_valid), 0);
    chk("halted pc", 32'(f.pc), 2);
    chk("halted flag", 32'(f.halted), 1);
    drive(0, 1, 0); step();
    chk("resume halted", 32'(f.halted), 0);
    drive(0, 0, 0); step();
    chk("resume instr", f.if_id_instr, 32'h200);
    check_model();
    mem[2] = 32'h204;
    drive(0, 1, 0); step();
    drive(0, 0, 0); step(); step();
    chk("pre-reset pc", 32'(f.pc), 2);
    #2 reset = 1'b0;
    model_reset();
    #1;
    chk("async pc", 32'(f.pc), 0);
    chk("async valid", 32'(f.if_id_valid), 0);
    chk("async count", 32'(f.fetch_count), 0);
    chk("async imem_reset", 32'(f.imem_reset), 1);
    #2 reset = 1'b1;
    step();
    chk("reboot valid", 32'(f.if_id_valid), 0);
    chk("reboot imem_reset", 32'(f.imem_reset), 0);
    step();
    chk("refetch instr", f.if_id_instr, 32'h200);
    check_model();
    for (int i = 0; i < 32; i++) mem[i] = ($urandom_range(5) == 0) ? HALT : $urandom;
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(3) == 0, $urandom_range(7) == 0, 5'($urandom));
      step();
      check_model();
    end
    for (int i = 0; i < 32; i++) mem[i] = 32'(i) + 32'h100;
    drive(0, 1, 0); step();
    drive(0, 0, 0);
    repeat (65540) step();
    check_model();
    chk("count saturated", 32'(f.fetch_count), 32'hFFFF);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
